// File: rtl/prbs4_checker_if.sv
// prbs4_checker_if: word stream and status bundle for the PRBS4 checker.
// Signals:
//   valid_i, data_i[3:0], clear_i           : receive stream and clear request
//   locked_o, err_o, err_cnt_o[CNT_W-1:0]   : lock status, error pulse, error count
//   expected_o[3:0], lockup_o               : predicted next word, sticky all-zero flag
// Modports: master (stream source / status sink), slave (checker).
interface prbs4_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             valid_i;
    logic [3:0]       data_i;
    logic             clear_i;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [3:0]       expected_o;
    logic             lockup_o;

    modport master (
        output valid_i, data_i, clear_i,
        input  locked_o, err_o, err_cnt_o, expected_o, lockup_o
    );

    modport slave (
        input  valid_i, data_i, clear_i,
        output locked_o, err_o, err_cnt_o, expected_o, lockup_o
    );
endinterface

// File: rtl/prbs4_checker.sv
// prbs4_checker: synchronises to the x^4+x^2+1 4-bit pattern, counts and
// flags mismatched words once locked.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : prbs4_checker_if.slave (valid_i/data_i/clear_i in; status out)
// Parameters: LOCK_CNT (matches to lock), LOSS_CNT (misses to unlock),
//             CNT_W (error counter width).
// Optional feature: define PRBS4_CHK_LOCKUP_DET_EN to enable the sticky
// all-zero lockup flag and the forced unlock on a 0000 word.
module prbs4_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    prbs4_checker_if.slave bus
);
    localparam int unsigned MATCH_W = ($clog2(LOCK_CNT + 1) > 0) ? $clog2(LOCK_CNT + 1) : 1;
    localparam int unsigned MISS_W  = ($clog2(LOSS_CNT + 1) > 0) ? $clog2(LOSS_CNT + 1) : 1;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Pattern successor: shift left, feed back bit3 ^ bit1
    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[1]};
    endfunction

    logic [0:0]         r_state;
    logic               r_seeded;
    logic [3:0]         r_prev;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [MISS_W-1:0]  r_miss_cnt;
    logic [3:0]         r_expected;
    logic               r_err;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [0:0]         w_state_nxt;
    logic               w_seeded_nxt;
    logic [3:0]         w_prev_nxt;
    logic [MATCH_W-1:0] w_match_nxt;
    logic [MISS_W-1:0]  w_miss_nxt;
    logic [3:0]         w_expected_nxt;
    logic               w_err_nxt;

    logic               w_zero;
    logic               w_hunt_hit;
    logic               w_locked_bad;
    logic               w_zero_loss;
    logic [MATCH_W-1:0] w_match_inc;
    logic [MISS_W-1:0]  w_miss_inc;

    assign w_zero       = (bus.data_i == 4'b0000);
    assign w_hunt_hit   = (bus.data_i == lfsr_next(r_prev)) && !w_zero;
    assign w_locked_bad = (bus.data_i != r_expected);
    assign w_match_inc  = r_match_cnt + MATCH_W'(1);
    assign w_miss_inc   = r_miss_cnt + MISS_W'(1);

`ifdef PRBS4_CHK_LOCKUP_DET_EN
    assign w_zero_loss = w_zero;
`else
    assign w_zero_loss = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_seeded_nxt   = r_seeded;
        w_prev_nxt     = r_prev;
        w_match_nxt    = r_match_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_expected_nxt = r_expected;
        w_err_nxt      = 1'b0;

        if (bus.valid_i) begin
            if (r_state == ST_HUNT) begin
                w_prev_nxt = bus.data_i;
                if (!r_seeded) begin
                    // First word after reset only loads the seed
                    w_seeded_nxt = 1'b1;
                    w_match_nxt  = '0;
                end else if (w_hunt_hit) begin
                    if (w_match_inc == MATCH_W'(LOCK_CNT)) begin
                        w_state_nxt    = ST_LOCKED;
                        w_match_nxt    = '0;
                        w_miss_nxt     = '0;
                        w_expected_nxt = lfsr_next(bus.data_i);
                    end else begin
                        w_match_nxt = w_match_inc;
                    end
                end else begin
                    w_match_nxt = '0;
                end
            end else begin
                // Free-running prediction: one corrupted word costs one error
                w_expected_nxt = lfsr_next(r_expected);
                if (w_locked_bad) begin
                    w_err_nxt  = 1'b1;
                    w_miss_nxt = w_miss_inc;
                    if ((w_miss_inc == MISS_W'(LOSS_CNT)) || w_zero_loss) begin
                        // Offending word becomes the seed for the next hunt
                        w_state_nxt  = ST_HUNT;
                        w_prev_nxt   = bus.data_i;
                        w_seeded_nxt = 1'b1;
                        w_match_nxt  = '0;
                    end
                end else begin
                    w_miss_nxt = '0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seeded    <= 1'b0;
            r_prev      <= 4'b0000;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_expected  <= 4'b0000;
            r_err       <= 1'b0;
        end else begin
            r_seeded    <= w_seeded_nxt;
            r_prev      <= w_prev_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_expected  <= w_expected_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Saturating error counter; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (bus.clear_i) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

`ifdef PRBS4_CHK_LOCKUP_DET_EN
    logic r_lockup;

    // Sticky all-zero flag; clear wins over set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lockup <= 1'b0;
        end else if (bus.clear_i) begin
            r_lockup <= 1'b0;
        end else if (bus.valid_i && w_zero) begin
            r_lockup <= 1'b1;
        end
    end

    assign bus.lockup_o = r_lockup;
`else
    assign bus.lockup_o = 1'b0;
`endif

    assign bus.locked_o   = (r_state == ST_LOCKED);
    assign bus.err_o      = r_err;
    assign bus.err_cnt_o  = r_err_cnt;
    assign bus.expected_o = r_expected;
endmodule

// File: tb/tb_prbs4_checker.sv
// tb_prbs4_checker: randomized and directed stimulus for prbs4_checker,
// scoreboarded against a table-driven reference model.
module tb_prbs4_checker;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned LOSS_CNT = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    prbs4_checker_if #(.CNT_W(CNT_W)) bus();

    prbs4_checker #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit         locked;
        bit         err;
        int         cnt;
        logic [3:0] expw;
        bit         lockup;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Successor table built from the three orbits of the pattern map
    logic [3:0] succ [16];

    // Reference model state
    bit         m_locked;
    bit         m_seeded;
    logic [3:0] m_prev;
    logic [3:0] m_expw;
    int         m_match;
    int         m_miss;
    int         m_cnt;
    bit         m_lockup;
    bit         m_err;
    logic [3:0] tx;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic build_succ();
        int a[6] = '{1, 2, 5, 10, 4, 8};
        int b[6] = '{3, 7, 15, 14, 12, 9};
        int c[3] = '{6, 13, 11};
        succ[0] = 4'd0;
        for (int i = 0; i < 6; i++) succ[a[i]] = 4'(a[(i + 1) % 6]);
        for (int i = 0; i < 6; i++) succ[b[i]] = 4'(b[(i + 1) % 6]);
        for (int i = 0; i < 3; i++) succ[c[i]] = 4'(c[(i + 1) % 3]);
    endtask

    task automatic model_reset();
        m_locked = 0; m_seeded = 0; m_prev = 0; m_expw = 0;
        m_match = 0; m_miss = 0; m_cnt = 0; m_lockup = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit c);
        bit         inc;
        bit         zset;
        logic [3:0] want;
        inc  = 0;
        zset = 0;
        m_err = 0;
        if (v) begin
`ifdef PRBS4_CHK_LOCKUP_DET_EN
            zset = (d == 4'd0);
`endif
            if (!m_locked) begin
                if (!m_seeded) begin
                    m_seeded = 1;
                    m_match  = 0;
                end else if (d == succ[m_prev] && d != 4'd0) begin
                    m_match++;
                end else begin
                    m_match = 0;
                end
                m_prev = d;
                if (m_match == int'(LOCK_CNT)) begin
                    m_locked = 1;
                    m_expw   = succ[d];
                    m_miss   = 0;
                    m_match  = 0;
                end
            end else begin
                want   = m_expw;
                m_expw = succ[m_expw];
                if (d != want) begin
                    m_err = 1;
                    inc   = 1;
                    m_miss++;
                    if (m_miss == int'(LOSS_CNT) || zset) begin
                        m_locked = 0;
                        m_prev   = d;
                        m_seeded = 1;
                        m_match  = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) begin
            m_cnt    = 0;
            m_lockup = 0;
        end else begin
            if (inc && m_cnt < CNT_MAX) m_cnt++;
            if (zset) m_lockup = 1;
        end
    endtask

    // One cycle of stimulus; expectation for the following edge is queued
    task automatic drive(input bit v, input logic [3:0] d, input bit c);
        exp_t e;
        @(negedge clk);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.clear_i = c;
        model_step(v, d, c);
        e.locked = m_locked;
        e.err    = m_err;
        e.cnt    = m_cnt;
        e.expw   = m_expw;
        e.lockup = m_lockup;
        sb_q.push_back(e);
    endtask

    // Sample just after the edge the queued expectation refers to
    task automatic spot_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"},   int'(bus.locked_o),   0);
        check({tag, "_err"},      int'(bus.err_o),      0);
        check({tag, "_cnt"},      int'(bus.err_cnt_o),  0);
        check({tag, "_expected"}, int'(bus.expected_o), 0);
        check({tag, "_lockup"},   int'(bus.lockup_o),   0);
    endtask

    task automatic send_tx(input int err_pct);
        logic [3:0] d;
        d = tx;
        if ($urandom_range(0, 99) < err_pct) d = 4'($urandom_range(0, 15));
        tx = succ[tx];
        drive(1'b1, d, 1'b0);
    endtask

    task automatic run_random(input int n, input int err_pct, input int valid_pct, input int clr_per_mille);
        bit v;
        bit c;
        logic [3:0] d;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 99) < valid_pct);
            c = ($urandom_range(0, 999) < clr_per_mille);
            d = 4'($urandom_range(0, 15));
            if (v) begin
                d = tx;
                if ($urandom_range(0, 99) < err_pct) d = 4'($urandom_range(0, 15));
                tx = succ[tx];
            end
            drive(v, d, c);
        end
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_locked", int'(bus.locked_o),  int'(e.locked));
            check("sb_err",    int'(bus.err_o),     int'(e.err));
            check("sb_cnt",    int'(bus.err_cnt_o), e.cnt);
            check("sb_lockup", int'(bus.lockup_o),  int'(e.lockup));
            if (e.locked) check("sb_expected", int'(bus.expected_o), int'(e.expw));
        end
    end

    initial begin
        build_succ();
        model_reset();
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = 4'd0;
        bus.clear_i = 1'b0;
        #1;
        check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Lock on the reference cycle
        drive(1, 4'd1, 0); drive(1, 4'd2, 0); drive(1, 4'd5, 0);
        drive(1, 4'd10, 0); drive(1, 4'd4, 0);
        spot_wait();
        check("lock_locked",   int'(bus.locked_o),   1);
        check("lock_expected", int'(bus.expected_o), 8);
        check("lock_cnt",      int'(bus.err_cnt_o),  0);

        // Single corrupted word
        drive(1, 4'd8, 0); drive(1, 4'd15, 0);
        spot_wait();
        check("single_err",    int'(bus.err_o),     1);
        check("single_cnt",    int'(bus.err_cnt_o), 1);
        check("single_locked", int'(bus.locked_o),  1);
        drive(1, 4'd2, 0);
        spot_wait();
        check("single_recover", int'(bus.err_o), 0);

        // Loss of lock after three misses, then relock
        drive(1, 4'd15, 0); drive(1, 4'd15, 0); drive(1, 4'd15, 0);
        spot_wait();
        check("loss_locked", int'(bus.locked_o),  0);
        check("loss_cnt",    int'(bus.err_cnt_o), 4);
        drive(1, 4'd8, 0); drive(1, 4'd1, 0); drive(1, 4'd2, 0);
        drive(1, 4'd5, 0); drive(1, 4'd10, 0);
        spot_wait();
        check("relock_locked", int'(bus.locked_o), 1);

        // Idle gap is transparent; clear beats a simultaneous increment
        for (int i = 0; i < 7; i++) drive(0, 4'($urandom_range(0, 15)), 0);
        drive(1, 4'd4, 0); drive(1, 4'd8, 0);
        spot_wait();
        check("gap_err", int'(bus.err_o), 0);
        drive(1, 4'd15, 1);
        spot_wait();
        check("clear_err", int'(bus.err_o),     1);
        check("clear_cnt", int'(bus.err_cnt_o), 0);

`ifdef PRBS4_CHK_LOCKUP_DET_EN
        drive(1, 4'd0, 0);
        spot_wait();
        check("zero_lockup", int'(bus.lockup_o),  1);
        check("zero_locked", int'(bus.locked_o),  0);
        check("zero_cnt",    int'(bus.err_cnt_o), 1);
`endif

        // Randomized phases: clean, noisy, heavy errors without clear
        tx = 4'd3;
        run_random(300, 2, 85, 10);
        run_random(400, 40, 90, 0);
        run_random(300, 15, 70, 20);

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        tx = 4'd6;
        run_random(400, 5, 80, 10);
        run_random(200, 30, 95, 5);

        spot_wait();
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
